// File: rtl/id_queue.sv
// id_queue -- instruction queue between fetch and execute, with decode at pop.
//
// Fetch pushes up to IN_W instructions per cycle into a DEPTH-entry FIFO.
// Each cycle the head entry is decoded and, when the output register is free
// or being consumed, loaded into the registered out_* bundle.
//
// Build option: define ID_TLB_INST_EN to accept COP0 tlbr/tlbwi/tlbp as legal.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop all queued and output-held instructions
//   in_valid[IN_W]      per-slot valid, contiguous from slot 0
//   in_pc               PC of slot 0 (slot i = in_pc + 4*i)
//   in_inst[32*IN_W]    instruction words, slot i at [32i+31:32i]
//   in_addr_error[IN_W] fetch address error per slot
//   in_ready            push accepted this cycle
//   out_valid/out_ready output handshake
//   out_pc, out_inst    held instruction
//   out_ex              {addr_error, reserved, 0, break, syscall, 0}
//   out_load/store/branch/eret/ds, out_regwen, out_wreg  decode results
module id_queue #(
    parameter int DEPTH = 4,
    parameter int IN_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IN_W-1:0]   in_valid,
    input  logic [31:0]       in_pc,
    input  logic [32*IN_W-1:0] in_inst,
    input  logic [IN_W-1:0]   in_addr_error,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [5:0]        out_ex,
    output logic              out_load,
    output logic              out_store,
    output logic              out_branch,
    output logic              out_eret,
    output logic              out_ds,
    output logic              out_regwen,
    output logic [4:0]        out_wreg
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage (no reset needed: guarded by count)
    logic [31:0] r_pc_q   [DEPTH];
    logic [31:0] r_inst_q [DEPTH];
    logic        r_ae_q   [DEPTH];

    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ds_pend;

    logic          r_out_valid, r_load, r_store, r_branch, r_eret, r_ds, r_regwen;
    logic [31:0]   r_pc, r_inst;
    logic [5:0]    r_ex;
    logic [4:0]    r_wreg;

    logic [CW-1:0] w_npush;
    logic          w_push, w_pop;
    logic [31:0]   w_hi;
    logic          w_hae;

    always_comb begin
        w_npush = '0;
        for (int i = 0; i < IN_W; i++)
            if (in_valid[i]) w_npush = w_npush + CW'(1);
    end

    // Readiness looks only at the registered count so fetch never depends
    // combinationally on downstream out_ready.
    assign in_ready = !flush && (r_count <= CW'(DEPTH - IN_W));
    assign w_push   = in_ready && (|in_valid);
    assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);
    assign w_hi     = r_inst_q[r_rptr];
    assign w_hae    = r_ae_q[r_rptr];

    // ---------------- decode of the head entry ----------------
    logic       w_ri, w_ld, w_st, w_br, w_er, w_sc, w_bk, w_rw;
    logic [4:0] w_wr;
    logic [5:0] w_op, w_fn;
    logic [4:0] w_rs, w_rt, w_rd, w_sa;

    assign w_op = w_hi[31:26];
    assign w_rs = w_hi[25:21];
    assign w_rt = w_hi[20:16];
    assign w_rd = w_hi[15:11];
    assign w_sa = w_hi[10:6];
    assign w_fn = w_hi[5:0];

    always_comb begin
        w_ri = 1'b1; w_ld = 1'b0; w_st = 1'b0; w_br = 1'b0;
        w_er = 1'b0; w_sc = 1'b0; w_bk = 1'b0; w_rw = 1'b0; w_wr = 5'd0;
        case (w_op)
            6'h00: case (w_fn)
                6'h00, 6'h02, 6'h03:
                    if (w_rs == 5'd0) begin w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rd; end
                6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B:
                    if (w_sa == 5'd0) begin w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rd; end
                6'h08:
                    if (w_hi[20:6] == 15'd0) begin w_ri = 1'b0; w_br = 1'b1; end
                6'h09:
                    if (w_rt == 5'd0 && w_sa == 5'd0) begin
                        w_ri = 1'b0; w_br = 1'b1; w_rw = 1'b1; w_wr = w_rd;
                    end
                6'h0C: begin w_ri = 1'b0; w_sc = 1'b1; end
                6'h0D: begin w_ri = 1'b0; w_bk = 1'b1; end
                6'h10, 6'h12:
                    if (w_rs == 5'd0 && w_rt == 5'd0 && w_sa == 5'd0) begin
                        w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rd;
                    end
                6'h11, 6'h13:
                    if (w_hi[20:6] == 15'd0) w_ri = 1'b0;
                6'h18, 6'h19, 6'h1A, 6'h1B:
                    if (w_hi[15:6] == 10'd0) w_ri = 1'b0;
                default: ;
            endcase
            6'h01: case (w_rt)
                5'h00, 5'h01: begin w_ri = 1'b0; w_br = 1'b1; end
                5'h10, 5'h11: begin w_ri = 1'b0; w_br = 1'b1; w_rw = 1'b1; w_wr = 5'd31; end
                default: ;
            endcase
            6'h02, 6'h04, 6'h05: begin w_ri = 1'b0; w_br = 1'b1; end
            6'h03: begin w_ri = 1'b0; w_br = 1'b1; w_rw = 1'b1; w_wr = 5'd31; end
            6'h06, 6'h07:
                if (w_rt == 5'd0) begin w_ri = 1'b0; w_br = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E:
                begin w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rt; end
            6'h0F:
                if (w_rs == 5'd0) begin w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rt; end
            6'h10: begin
                if (w_rs == 5'd0 && w_hi[10:3] == 8'd0) begin
                    w_ri = 1'b0; w_rw = 1'b1; w_wr = w_rt;          // mfc0
                end else if (w_rs == 5'd4 && w_hi[10:3] == 8'd0) begin
                    w_ri = 1'b0;                                     // mtc0
                end else if (w_hi[25] && w_hi[24:6] == 19'd0) begin
                    if (w_fn == 6'h18) begin w_ri = 1'b0; w_er = 1'b1; end
`ifdef ID_TLB_INST_EN
                    if (w_fn == 6'h01 || w_fn == 6'h02 || w_fn == 6'h08) w_ri = 1'b0;
`else
`endif
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                begin w_ri = 1'b0; w_ld = 1'b1; w_rw = 1'b1; w_wr = w_rt; end
            6'h28, 6'h29, 6'h2B: begin w_ri = 1'b0; w_st = 1'b1; end
            6'h2F: w_ri = 1'b0;
            default: ;
        endcase
    end

    // ---------------- storage write ----------------
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i]) begin
                    r_pc_q[r_wptr + PW'(i)]   <= in_pc + 32'(4 * i);
                    r_inst_q[r_wptr + PW'(i)] <= in_inst[32*i +: 32];
                    r_ae_q[r_wptr + PW'(i)]   <= in_addr_error[i];
                end
            end
        end
    end

    // ---------------- control and output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_ds_pend <= 1'b0;
            r_out_valid <= 1'b0; r_pc <= '0; r_inst <= '0; r_ex <= '0;
            r_load <= 1'b0; r_store <= 1'b0; r_branch <= 1'b0; r_eret <= 1'b0;
            r_ds <= 1'b0; r_regwen <= 1'b0; r_wreg <= '0;
        end else if (flush) begin
            r_wptr <= '0; r_rptr <= '0; r_count <= '0;
            r_ds_pend <= 1'b0; r_out_valid <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(w_npush);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (w_push ? w_npush : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_pc        <= r_pc_q[r_rptr];
                r_inst      <= w_hi;
                r_ex        <= {w_hae, w_ri, 1'b0, w_bk, w_sc, 1'b0};
                r_load      <= w_ld;
                r_store     <= w_st;
                r_branch    <= w_br;
                r_eret      <= w_er;
                r_regwen    <= w_rw;
                r_wreg      <= w_wr;
                // delay slot: whatever pops right after a branch
                r_ds        <= r_ds_pend;
                r_ds_pend   <= w_br;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pc     = r_pc;
    assign out_inst   = r_inst;
    assign out_ex     = r_ex;
    assign out_load   = r_load;
    assign out_store  = r_store;
    assign out_branch = r_branch;
    assign out_eret   = r_eret;
    assign out_ds     = r_ds;
    assign out_regwen = r_regwen;
    assign out_wreg   = r_wreg;
endmodule

// File: tb/tb_id_queue.sv
module tb_id_queue;
    localparam int DEPTH = 4;
    localparam int IN_W  = 2;

    logic clk = 1'b0;
    logic rst, flush, in_ready, out_valid, out_ready;
    logic [IN_W-1:0] in_valid, in_addr_error;
    logic [31:0] in_pc, out_pc, out_inst;
    logic [32*IN_W-1:0] in_inst;
    logic [5:0] out_ex;
    logic out_load, out_store, out_branch, out_eret, out_ds, out_regwen;
    logic [4:0] out_wreg;

    always #5 clk = ~clk;

    id_queue #(.DEPTH(DEPTH), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_addr_error(in_addr_error), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_ex(out_ex), .out_load(out_load), .out_store(out_store), .out_branch(out_branch),
        .out_eret(out_eret), .out_ds(out_ds), .out_regwen(out_regwen), .out_wreg(out_wreg));

    int n_tests = 0, n_fail = 0;

    // Legal encodings as mask/match pairs; fl = {load,store,branch,eret,syscall,break};
    // wsel: 0 none, 1 rd, 2 rt, 3 r31
    typedef struct { logic [31:0] mask; logic [31:0] match; int wsel; logic [5:0] fl; } pat_t;
    pat_t pats[$];
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic ae; } ent_t;
    ent_t q[$];

    logic m_ov, m_ld, m_st, m_br, m_er, m_ds, m_rw, m_dsp;
    logic [31:0] m_pc, m_inst;
    logic [5:0] m_ex;
    logic [4:0] m_wr;

    localparam logic [5:0] LD = 6'b100000, ST = 6'b010000, BR = 6'b001000,
                           ER = 6'b000100, SC = 6'b000010, BK = 6'b000001;

    function automatic void addp(logic [31:0] mask, logic [31:0] match, int wsel, logic [5:0] fl);
        pat_t p;
        p.mask = mask; p.match = match; p.wsel = wsel; p.fl = fl;
        pats.push_back(p);
    endfunction

    task automatic build_pats();
        int sh[3] = '{0, 2, 3};
        int sv[3] = '{4, 6, 7};
        int alu[10] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A, 32'h2B};
        int lds[5] = '{32'h20, 32'h21, 32'h23, 32'h24, 32'h25};
        int sts[3] = '{32'h28, 32'h29, 32'h2B};
        foreach (sh[k])  addp(32'hFFE0003F, 32'(sh[k]), 1, 0);
        foreach (sv[k])  addp(32'hFC0007FF, 32'(sv[k]), 1, 0);
        foreach (alu[k]) addp(32'hFC0007FF, 32'(alu[k]), 1, 0);
        addp(32'hFC1FFFFF, 32'h08, 0, BR);            // jr
        addp(32'hFC1F07FF, 32'h09, 1, BR);            // jalr
        addp(32'hFC00003F, 32'h0C, 0, SC);
        addp(32'hFC00003F, 32'h0D, 0, BK);
        addp(32'hFFFF07FF, 32'h10, 1, 0);             // mfhi
        addp(32'hFFFF07FF, 32'h12, 1, 0);             // mflo
        addp(32'hFC1FFFFF, 32'h11, 0, 0);             // mthi
        addp(32'hFC1FFFFF, 32'h13, 0, 0);             // mtlo
        for (int f = 32'h18; f <= 32'h1B; f++) addp(32'hFC00FFFF, 32'(f), 0, 0);
        addp(32'hFC1F0000, 32'h04000000, 0, BR);      // bltz
        addp(32'hFC1F0000, 32'h04010000, 0, BR);      // bgez
        addp(32'hFC1F0000, 32'h04100000, 3, BR);      // bltzal
        addp(32'hFC1F0000, 32'h04110000, 3, BR);      // bgezal
        addp(32'hFC000000, 32'h08000000, 0, BR);      // j
        addp(32'hFC000000, 32'h0C000000, 3, BR);      // jal
        addp(32'hFC000000, 32'h10000000, 0, BR);      // beq
        addp(32'hFC000000, 32'h14000000, 0, BR);      // bne
        addp(32'hFC1F0000, 32'h18000000, 0, BR);      // blez
        addp(32'hFC1F0000, 32'h1C000000, 0, BR);      // bgtz
        for (int op = 8; op <= 14; op++) addp(32'hFC000000, 32'(op) << 26, 2, 0);
        addp(32'hFFE00000, 32'h3C000000, 2, 0);       // lui
        addp(32'hFFE007F8, 32'h40000000, 2, 0);       // mfc0
        addp(32'hFFE007F8, 32'h40800000, 0, 0);       // mtc0
        addp(32'hFFFFFFFF, 32'h42000018, 0, ER);      // eret
`ifdef ID_TLB_INST_EN
        addp(32'hFFFFFFFF, 32'h42000001, 0, 0);
        addp(32'hFFFFFFFF, 32'h42000002, 0, 0);
        addp(32'hFFFFFFFF, 32'h42000008, 0, 0);
`endif
        foreach (lds[k]) addp(32'hFC000000, 32'(lds[k]) << 26, 2, LD);
        foreach (sts[k]) addp(32'hFC000000, 32'(sts[k]) << 26, 0, ST);
        addp(32'hFC000000, 32'hBC000000, 0, 0);       // cache
    endtask

    task automatic mpop();
        ent_t e;
        int hit;
        logic ri;
        logic [5:0] fl;
        e = q.pop_front();
        hit = -1;
        foreach (pats[k]) if (hit < 0 && (e.inst & pats[k].mask) == pats[k].match) hit = k;
        m_pc = e.pc; m_inst = e.inst; m_ov = 1'b1; m_ds = m_dsp;
        m_rw = 1'b0; m_wr = 5'd0; fl = 6'd0; ri = 1'b1;
        if (hit >= 0) begin
            ri = 1'b0; fl = pats[hit].fl;
            case (pats[hit].wsel)
                1: begin m_rw = 1'b1; m_wr = e.inst[15:11]; end
                2: begin m_rw = 1'b1; m_wr = e.inst[20:16]; end
                3: begin m_rw = 1'b1; m_wr = 5'd31; end
                default: ;
            endcase
        end
        {m_ld, m_st, m_br, m_er} = fl[5:2];
        m_ex = {e.ae, ri, 1'b0, fl[0], fl[1], 1'b0};
        m_dsp = fl[3];
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_ld = 0; m_st = 0; m_br = 0; m_er = 0; m_ds = 0; m_rw = 0; m_dsp = 0;
        m_pc = 0; m_inst = 0; m_ex = 0; m_wr = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, m_inst);
            chk("out_ex", 32'(out_ex), 32'(m_ex));
            chk("out_flags", 32'({out_load, out_store, out_branch, out_eret, out_ds}),
                32'({m_ld, m_st, m_br, m_er, m_ds}));
            chk("out_regwen", 32'(out_regwen), 32'(m_rw));
            if (m_rw) chk("out_wreg", 32'(out_wreg), 32'(m_wr));
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs at negedge.
    task automatic step(input logic [IN_W-1:0] v, input logic [31:0] pc,
                        input logic [32*IN_W-1:0] inst, input logic [IN_W-1:0] ae,
                        input logic orr, input logic fl);
        logic rdy;
        in_valid = v; in_pc = pc; in_inst = inst; in_addr_error = ae;
        out_ready = orr; flush = fl;
        #1;
        rdy = !fl && (DEPTH - q.size() >= IN_W);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        if (fl) begin
            q.delete(); m_ov = 1'b0; m_dsp = 1'b0;
        end else begin
            if (q.size() > 0 && (!m_ov || orr)) mpop();
            else if (orr) m_ov = 1'b0;
            if (rdy) for (int i = 0; i < IN_W; i++)
                if (v[i]) begin
                    ent_t e;
                    e.pc = pc + 32'(4 * i); e.inst = inst[32*i +: 32]; e.ae = ae[i];
                    q.push_back(e);
                end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 32'd0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = '0; flush = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_ex", 32'(out_ex), 32'd0);
        chk("rst_out_wreg", 32'({out_regwen, out_wreg, out_ds, out_branch, out_load}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_inst();
        int r;
        pat_t p;
        logic [31:0] x;
        r = $urandom_range(0, 9);
        if (r >= 8) return $urandom;
        p = pats[$urandom_range(0, pats.size() - 1)];
        x = ($urandom & ~p.mask) | p.match;
        if (r >= 6) x[$urandom_range(0, 31)] ^= 1'b1;
        return x;
    endfunction

    initial begin
        logic [IN_W-1:0] v, ae;
        int n;
        build_pats();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0;
        in_pc = '0; in_inst = '0; in_addr_error = '0;
        @(negedge clk);
        do_reset();

        // addiu/lw pair: consecutive pops, latency of one edge
        step(2'b11, 32'h1000, {32'h8C870000, 32'h24050001}, 2'b00, 1'b1, 1'b0);
        chk("A_lat", 32'(out_valid), 32'd0);
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("A_pc0", out_pc, 32'h1000);
        chk("A_wreg0", 32'(out_wreg), 32'd5);
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("A_pc1", out_pc, 32'h1004);
        chk("A_ld1", 32'({out_load, out_wreg}), 32'({1'b1, 5'd7}));
        idle(1);

        // tlbr
        step(2'b01, 32'h2000, {32'd0, 32'h42000001}, 2'b00, 1'b1, 1'b0);
        step('0, 0, '0, '0, 1'b1, 1'b0);
`ifdef ID_TLB_INST_EN
        chk("B_tlbr", 32'(out_ex), 32'h00);
`else
        chk("B_tlbr", 32'(out_ex), 32'h10);
`endif
        // syscall with fetch address error
        step(2'b01, 32'h3000, {32'd0, 32'h0000000C}, 2'b01, 1'b1, 1'b0);
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("C_sys_ae", 32'(out_ex), 32'h22);
        idle(1);

        // beq, addu (delay slot), ori
        step(2'b11, 32'h4000, {32'h00221821, 32'h10220001}, 2'b00, 1'b1, 1'b0);
        step(2'b01, 32'h4008, {32'd0, 32'h34040005}, 2'b00, 1'b1, 1'b0);
        chk("D_br", 32'({out_branch, out_ds}), 32'b10);
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("D_ds", 32'({out_ds, out_wreg}), 32'({1'b1, 5'd3}));
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("D_nods", 32'(out_ds), 32'd0);
        idle(1);
        // flush between beq and addu
        step(2'b11, 32'h4100, {32'h00221821, 32'h10220001}, 2'b00, 1'b0, 1'b0);
        step('0, 0, '0, '0, 1'b0, 1'b0);
        step('0, 0, '0, '0, 1'b0, 1'b1);
        chk("D_flush", 32'(out_valid), 32'd0);
        step(2'b01, 32'h4104, {32'd0, 32'h00221821}, 2'b00, 1'b1, 1'b0);
        step('0, 0, '0, '0, 1'b1, 1'b0);
        chk("D_flush_ds", 32'({out_valid, out_ds}), 32'b10);
        idle(1);

        // fill with out_ready=0, then pop with concurrent push
        step(2'b01, 32'h5000, {32'd0, 32'h24010001}, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h5004, {32'h24030003, 32'h24020002}, 2'b00, 1'b0, 1'b0);
        chk("E_rdy2", 32'(in_ready), 32'd1);
        step(2'b11, 32'h500C, {32'h24050005, 32'h24040004}, 2'b00, 1'b0, 1'b0);
        chk("E_rdy4", 32'(in_ready), 32'd0);
        step(2'b01, 32'h5100, {32'd0, 32'h24060006}, 2'b00, 1'b1, 1'b0);
        chk("E_rdy3", 32'(in_ready), 32'd0);
        step(2'b11, 32'h5200, {32'h24080008, 32'h24070007}, 2'b00, 1'b1, 1'b0);
        chk("E_rdy2b", 32'(in_ready), 32'd1);
        step(2'b11, 32'h5300, {32'h240A000A, 32'h24090009}, 2'b00, 1'b1, 1'b0);
        idle(6);

        // reset with three entries queued
        step(2'b11, 32'h6000, {32'h24020002, 32'h24010001}, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h6008, {32'h24040004, 32'h24030003}, 2'b00, 1'b0, 1'b0);
        do_reset();
        idle(5);
        chk("F_no_stale", 32'(out_valid), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                n = $urandom_range(0, IN_W);
                v = IN_W'((1 << n) - 1);
                ae = '0;
                for (int i = 0; i < IN_W; i++) ae[i] = ($urandom_range(0, 7) == 0);
                step(v, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, {rand_inst(), rand_inst()},
                     ae, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_queue.md
ID_QUEUE -- requirements
Module: id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter IN_W, default 2, instructions accepted per push (1 or 2).
REQ-003 SHALL have port clk input 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush input 1: discard all queued and output-held instructions.
REQ-006 SHALL have port in_valid input IN_W: per-slot valid, contiguous from slot 0.
REQ-007 SHALL have port in_pc input 32: PC of slot 0; slot i PC = in_pc + 4*i.
REQ-008 SHALL have port in_inst input 32*IN_W: slot i at bits [32i+31:32i].
REQ-009 SHALL have port in_addr_error input IN_W: fetch address error per slot.
REQ-010 SHALL have port in_ready output 1: push accepted this cycle.
REQ-011 SHALL have port out_valid output 1: decoded instruction held.
REQ-012 SHALL have port out_ready input 1: downstream consumes.
REQ-013 SHALL have ports out_pc output 32 and out_inst output 32: held instruction.
REQ-014 SHALL have port out_ex output 6: {addr_error, reserved, 0, break, syscall, 0}.
REQ-015 SHALL have ports out_load, out_store, out_branch, out_eret, out_ds output 1 each: class flags; out_ds = in branch delay slot.
REQ-016 SHALL have ports out_regwen output 1 and out_wreg output 5: GPR write enable/target.

Function
REQ-017 SHALL push when any in_valid bit set and in_ready=1, writing popcount(in_valid) entries in slot order.
REQ-018 SHALL drive in_ready = (free entries >= IN_W) from registered count only, independent of same-cycle pop.
REQ-019 SHALL load output register when FIFO non-empty and (out_valid=0 or out_ready=1), popping one entry.
REQ-020 SHALL clear out_valid when out_ready=1 and FIFO empty.
REQ-021 SHALL give latency: push at edge N -> out_valid at edge N+1 earliest; no FIFO bypass.
REQ-022 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL support simultaneous push and pop; count += pushed - popped.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; full at count=DEPTH, empty at 0.
REQ-025 SHALL decode at pop time (registered outputs), legal set: SPECIAL sll srl sra sllv srlv srav jr jalr syscall break mfhi mthi mflo mtlo mult multu div divu add addu sub subu and or xor nor slt sltu; REGIMM bltz bgez bltzal bgezal; j jal beq bne blez bgtz addi addiu slti sltiu andi ori xori lui; COP0 mfc0 mtc0 eret; lb lh lw lbu lhu sb sh sw cache; mandatory-zero fields checked per MIPS32 encoding.
REQ-026 SHALL set out_ex[4] for any encoding outside the legal set; out_ex[5] from stored addr_error.
REQ-027 SHALL set out_branch for REGIMM branches, j, jal, beq, bne, blez, bgtz, jr, jalr.
REQ-028 SHALL set out_ds for the instruction popped next after one with out_branch=1, tracked by a register.
REQ-029 SHALL set out_wreg: rd for SPECIAL ALU/mfhi/mflo/jalr; 31 for jal/bltzal/bgezal; rt for immediate ALU, lui, loads, mfc0; out_regwen=0 for mult/div/mthi/mtlo/stores/branches without link.
REQ-030 SHALL on flush=1: empty FIFO, clear out_valid and delay-slot register at next edge; same-cycle push and pop ignored; in_ready=0 that cycle.

Reset
REQ-031 SHALL on rst: count, pointers, out_valid, delay-slot register = 0; all out_* = 0.
REQ-032 SHALL take effect immediately mid-operation, discarding queued entries; in_ready = 1 after release.

Configuration
REQ-033 SHALL with ID_TLB_INST_EN defined decode COP0 tlbr, tlbwi, tlbp as legal (out_ex[4]=0, out_regwen=0); without it treat them reserved (out_ex[4]=1).

Verification
REQ-034 SHALL cover: IN_W=2, push in_valid=2'b11 pc=0x1000 insts addiu/lw, out_ready=1 -> pc 0x1000 then 0x1004 on consecutive cycles, out_wreg=rt, out_load on second.
REQ-035 SHALL cover: fill DEPTH=4 with out_ready=0 -> in_ready=0 at count 3 and 4; out_ready=1 with push same cycle -> count stays consistent, no loss/duplication.
REQ-036 SHALL cover: beq then addu -> addu out_ds=1, next instruction out_ds=0; flush between them clears out_ds.
REQ-037 SHALL cover: inst 0x42000001 (tlbr) -> out_ex=6'b010000 without macro, 6'b000000 with ID_TLB_INST_EN.
REQ-038 SHALL cover: rst asserted with 3 entries queued -> out_valid=0 immediately, in_ready=1 after release, no stale entry ever emitted.
REQ-039 SHALL cover: in_addr_error=1 with syscall inst 0x0000000C -> out_ex=6'b100010.
